// File: rtl/disp_pkg.sv
// disp_pkg: shared display-pipeline types, timing-mode constants and pattern colours.
// Used by disp_timing_ctrl and its sync delay line.
package disp_pkg;

    typedef logic [11:0] coord_t;
    typedef logic [23:0] pixel_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } run_state_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic sof;
    } sync_bundle_t;

    localparam int unsigned CNT_LIMIT       = 4096;
    localparam int unsigned SYNC_PIPE_DEPTH = 3;

    // 1080p60
    localparam int unsigned H_SYNC_1080   = 44;
    localparam int unsigned H_BACK_1080   = 148;
    localparam int unsigned H_ACTIVE_1080 = 1920;
    localparam int unsigned H_FRONT_1080  = 88;
    localparam int unsigned V_SYNC_1080   = 5;
    localparam int unsigned V_BACK_1080   = 36;
    localparam int unsigned V_ACTIVE_1080 = 1080;
    localparam int unsigned V_FRONT_1080  = 4;

    // 720p60
    localparam int unsigned H_SYNC_720    = 40;
    localparam int unsigned H_BACK_720    = 220;
    localparam int unsigned H_ACTIVE_720  = 1280;
    localparam int unsigned H_FRONT_720   = 110;
    localparam int unsigned V_SYNC_720    = 5;
    localparam int unsigned V_BACK_720    = 20;
    localparam int unsigned V_ACTIVE_720  = 720;
    localparam int unsigned V_FRONT_720   = 5;

    localparam pixel_t COL_WHITE   = 24'hFFFFFF;
    localparam pixel_t COL_YELLOW  = 24'hFFFF00;
    localparam pixel_t COL_CYAN    = 24'h00FFFF;
    localparam pixel_t COL_GREEN   = 24'h00FF00;
    localparam pixel_t COL_MAGENTA = 24'hFF00FF;
    localparam pixel_t COL_RED     = 24'hFF0000;
    localparam pixel_t COL_BLUE    = 24'h0000FF;
    localparam pixel_t COL_BLACK   = 24'h000000;

    function automatic logic in_window(input int unsigned c, input int unsigned lo,
                                       input int unsigned len);
        return (c >= lo) && (c < lo + len);
    endfunction

endpackage

// File: rtl/disp_sync_pipe.sv
// disp_sync_pipe: DEPTH-stage delay line for the {hs, vs, de, sof} bundle.
// All stages clear asynchronously so no stale sync/de leaks out after reset.
module disp_sync_pipe
    import disp_pkg::*;
#(
    parameter int unsigned DEPTH = SYNC_PIPE_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  sync_bundle_t i_bundle,
    output sync_bundle_t o_bundle
);

    sync_bundle_t r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_bundle;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_bundle = r_stage[DEPTH-1];

endmodule

// File: rtl/disp_timing_ctrl.sv
// disp_timing_ctrl: raster counters, pattern-generator addressing and 3-cycle aligned video out.
// Optional macro FRAME_CNT_EN: implements the frame_cnt counter; otherwise frame_cnt is tied to 0.
module disp_timing_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_1080,
    parameter int unsigned H_BACK   = H_BACK_1080,
    parameter int unsigned H_ACTIVE = H_ACTIVE_1080,
    parameter int unsigned H_FRONT  = H_FRONT_1080,
    parameter int unsigned V_SYNC   = V_SYNC_1080,
    parameter int unsigned V_BACK   = V_BACK_1080,
    parameter int unsigned V_ACTIVE = V_ACTIVE_1080,
    parameter int unsigned V_FRONT  = V_FRONT_1080,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [11:0] h_addr,
    output logic [11:0] v_addr,
    input  logic [23:0] data_in,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [23:0] vga_rgb,
    output logic        sof,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned V_START = V_SYNC + V_BACK;

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_START_C = coord_t'(H_START);
    localparam coord_t V_START_C = coord_t'(V_START);

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_timing
        $error("disp_timing_ctrl: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end

    run_state_e   r_state;
    run_state_e   w_state_next;
    coord_t       r_h_cnt;
    coord_t       r_v_cnt;
    coord_t       r_h_addr;
    coord_t       r_v_addr;
    pixel_t       r_rgb;
    logic         w_h_last;
    logic         w_v_last;
    logic         w_frame_end;
    logic         w_run;
    logic         w_de;
    sync_bundle_t w_sync_in;
    sync_bundle_t w_sync_out;

    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;
    assign w_run       = (r_state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stopping is only honoured at frame end so a dropped en always finishes the frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (en)                w_state_next = ST_RUN;
            ST_RUN:  if (w_frame_end && !en) w_state_next = ST_IDLE;
            default:                        w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_comb begin
        w_de          = w_run
                        && in_window(32'(r_h_cnt), H_START, H_ACTIVE)
                        && in_window(32'(r_v_cnt), V_START, V_ACTIVE);
        w_sync_in     = '0;
        w_sync_in.hs  = w_run && in_window(32'(r_h_cnt), 0, H_SYNC);
        w_sync_in.vs  = w_run && in_window(32'(r_v_cnt), 0, V_SYNC);
        w_sync_in.de  = w_de;
        w_sync_in.sof = w_de && (r_h_cnt == H_START_C) && (r_v_cnt == V_START_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_addr <= '0;
            r_v_addr <= '0;
        end else if (w_de) begin
            r_h_addr <= r_h_cnt - H_START_C;
            r_v_addr <= r_v_cnt - V_START_C;
        end else begin
            r_h_addr <= '0;
            r_v_addr <= '0;
        end
    end

    disp_sync_pipe #(
        .DEPTH (SYNC_PIPE_DEPTH)
    ) u_sync_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bundle (w_sync_in),
        .o_bundle (w_sync_out)
    );

    // data_in arrives at stage 2; registering it lines it up with stage 3 of the sync pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= data_in;
        end
    end

    assign h_addr  = r_h_addr;
    assign v_addr  = r_v_addr;
    assign vga_hs  = w_sync_out.hs ? SYNC_POL : ~SYNC_POL;
    assign vga_vs  = w_sync_out.vs ? SYNC_POL : ~SYNC_POL;
    assign vga_de  = w_sync_out.de;
    assign sof     = w_sync_out.sof;
    assign vga_rgb = w_sync_out.de ? r_rgb : '0;

`ifdef FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_run && w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// Directed bench for disp_timing_ctrl using reduced raster geometries for short frames.
module tb_disp_timing_ctrl;

    localparam int HS1 = 4, HB1 = 3, HA1 = 8, HF1 = 2;
    localparam int VS1 = 2, VB1 = 2, VA1 = 5, VF1 = 1;
    localparam int HT1 = HS1 + HB1 + HA1 + HF1;
    localparam int VT1 = VS1 + VB1 + VA1 + VF1;

    localparam int HS2 = 3, HB2 = 2, HA2 = 4, HF2 = 1;
    localparam int VS2 = 1, VB2 = 1, VA2 = 2, VF2 = 1;
    localparam int HT2 = HS2 + HB2 + HA2 + HF2;
    localparam int VT2 = VS2 + VB2 + VA2 + VF2;

`ifdef FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en2;
    logic [11:0] h_addr, v_addr, h_addr2, v_addr2;
    logic [23:0] data_in = '0;
    logic [23:0] data_in2 = '0;
    logic        vga_hs, vga_vs, vga_de, sof;
    logic        vga_hs2, vga_vs2, vga_de2, sof2;
    logic [23:0] vga_rgb, vga_rgb2;
    logic [15:0] frame_cnt, frame_cnt2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Pattern-generator stand-in: one-cycle registered coordinate echo.
    always @(posedge clk) begin
        data_in  <= {v_addr, h_addr};
        data_in2 <= {v_addr2, h_addr2};
    end

    disp_timing_ctrl #(
        .H_SYNC(HS1), .H_BACK(HB1), .H_ACTIVE(HA1), .H_FRONT(HF1),
        .V_SYNC(VS1), .V_BACK(VB1), .V_ACTIVE(VA1), .V_FRONT(VF1),
        .SYNC_POL(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .h_addr(h_addr), .v_addr(v_addr),
        .data_in(data_in), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_rgb(vga_rgb), .sof(sof), .frame_cnt(frame_cnt)
    );

    disp_timing_ctrl #(
        .H_SYNC(HS2), .H_BACK(HB2), .H_ACTIVE(HA2), .H_FRONT(HF2),
        .V_SYNC(VS2), .V_BACK(VB2), .V_ACTIVE(VA2), .V_FRONT(VF2),
        .SYNC_POL(1'b0)
    ) u_dut_neg (
        .clk(clk), .rst_n(rst_n), .en(en2), .h_addr(h_addr2), .v_addr(v_addr2),
        .data_in(data_in2), .vga_hs(vga_hs2), .vga_vs(vga_vs2), .vga_de(vga_de2),
        .vga_rgb(vga_rgb2), .sof(sof2), .frame_cnt(frame_cnt2)
    );

    // Expected {hs, vs, de, sof, rgb} at output raster position i of a frame.
    function automatic logic [27:0] exp_vec(input int i, input int hsw, input int hb,
                                            input int ha, input int hf, input int vsw,
                                            input int vb, input int va, input bit pol);
        int ht, x, y, hst, vst;
        logic h, v, d, s;
        logic [11:0] ex, ey;
        ht  = hsw + hb + ha + hf;
        x   = i % ht;
        y   = i / ht;
        hst = hsw + hb;
        vst = vsw + vb;
        h   = (x < hsw) ? pol : ~pol;
        v   = (y < vsw) ? pol : ~pol;
        d   = (x >= hst) && (x < hst + ha) && (y >= vst) && (y < vst + va);
        s   = (x == hst) && (y == vst);
        ey  = 12'(y - vst);
        ex  = 12'(x - hst);
        return {h, v, d, s, d ? {ey, ex} : 24'h0};
    endfunction

    task automatic test_reset();
        logic [67:0] acc;
        rst_n = 1'b0;
        en    = 1'b0;
        en2   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({vga_hs, vga_vs, vga_de, sof, vga_rgb, h_addr, v_addr, frame_cnt} !== 68'h0) begin
            fails++;
            $display("FAIL reset_values: got %h expected 0",
                     {vga_hs, vga_vs, vga_de, sof, vga_rgb, h_addr, v_addr, frame_cnt});
        end
        checks++;
        if ({vga_hs2, vga_vs2, vga_de2, sof2, vga_rgb2, frame_cnt2} !== {2'b11, 42'h0}) begin
            fails++;
            $display("FAIL reset_values_neg: got %h expected %h",
                     {vga_hs2, vga_vs2, vga_de2, sof2, vga_rgb2, frame_cnt2}, {2'b11, 42'h0});
        end
        rst_n = 1'b1;
        acc   = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = acc | {vga_hs, vga_vs, vga_de, sof, vga_rgb, h_addr, v_addr, frame_cnt};
        end
        checks++;
        if (acc !== 68'h0) begin
            fails++;
            $display("FAIL idle_hold: OR of outputs %h expected 0", acc);
        end
    endtask

    task automatic test_first_hs();
        int n = 0;
        en = 1'b1;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (vga_hs === 1'b1) n = k;
        end
        checks++;
        if (n != 4) begin
            fails++;
            $display("FAIL first_hs_latency: got edge %0d expected 4", n);
        end
    endtask

    task automatic test_frame();
        logic [27:0] exp;
        for (int i = 0; i < HT1 * VT1; i++) begin
            exp = exp_vec(i, HS1, HB1, HA1, HF1, VS1, VB1, VA1, 1'b1);
            checks++;
            if ({vga_hs, vga_vs, vga_de, sof, vga_rgb} !== exp) begin
                fails++;
                $display("FAIL frame pos %0d: got %h expected %h", i,
                         {vga_hs, vga_vs, vga_de, sof, vga_rgb}, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (frame_cnt !== 16'(FC_EN ? 1 : 0)) begin
            fails++;
            $display("FAIL frame_cnt_one: got %0d expected %0d", frame_cnt, FC_EN ? 1 : 0);
        end
    endtask

    task automatic test_en_drop();
        logic [27:0] exp;
        logic [55:0] acc;
        for (int i = 0; i < HT1 * VT1; i++) begin
            if (i == 6 * HT1) en = 1'b0;
            exp = exp_vec(i, HS1, HB1, HA1, HF1, VS1, VB1, VA1, 1'b1);
            checks++;
            if ({vga_hs, vga_vs, vga_de, sof, vga_rgb} !== exp) begin
                fails++;
                $display("FAIL drop_frame pos %0d: got %h expected %h", i,
                         {vga_hs, vga_vs, vga_de, sof, vga_rgb}, exp);
            end
            @(negedge clk);
        end
        acc = '0;
        for (int c = 0; c < 200; c++) begin
            acc = acc | {vga_hs, vga_vs, vga_de, sof, vga_rgb, h_addr, v_addr};
            @(negedge clk);
        end
        checks++;
        if (acc !== 56'h0) begin
            fails++;
            $display("FAIL drop_parked: OR of outputs %h expected 0", acc);
        end
        checks++;
        if (frame_cnt !== 16'(FC_EN ? 2 : 0)) begin
            fails++;
            $display("FAIL drop_frame_cnt: got %0d expected %0d", frame_cnt, FC_EN ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] exp;
        int seen = 0;
        int n    = 0;
        en = 1'b1;
        for (int k = 0; k < 200 && seen == 0; k++) begin
            @(negedge clk);
            if (vga_de === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 1) begin
            fails++;
            $display("FAIL mid_wait_de: got no de within 200 cycles, required de=1");
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({vga_hs, vga_vs, vga_de, sof, vga_rgb, h_addr, v_addr, frame_cnt} !== 68'h0) begin
            fails++;
            $display("FAIL mid_reset_clear: got %h expected 0",
                     {vga_hs, vga_vs, vga_de, sof, vga_rgb, h_addr, v_addr, frame_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (vga_hs === 1'b1) n = k;
        end
        checks++;
        if (n != 4) begin
            fails++;
            $display("FAIL mid_restart_latency: got edge %0d expected 4", n);
        end
        for (int i = 0; i < 5 * HT1; i++) begin
            exp = exp_vec(i, HS1, HB1, HA1, HF1, VS1, VB1, VA1, 1'b1);
            checks++;
            if ({vga_hs, vga_vs, vga_de, sof, vga_rgb} !== exp) begin
                fails++;
                $display("FAIL mid_restart pos %0d: got %h expected %h", i,
                         {vga_hs, vga_vs, vga_de, sof, vga_rgb}, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sync_pol();
        logic [27:0] exp;
        int n = 0;
        checks++;
        if ({vga_hs2, vga_vs2, vga_de2} !== 3'b110) begin
            fails++;
            $display("FAIL neg_idle_levels: got %b expected 110", {vga_hs2, vga_vs2, vga_de2});
        end
        en2 = 1'b1;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (vga_hs2 === 1'b0) n = k;
        end
        checks++;
        if (n != 4) begin
            fails++;
            $display("FAIL neg_first_hs_latency: got edge %0d expected 4", n);
        end
        for (int i = 0; i < HT2 * VT2; i++) begin
            exp = exp_vec(i, HS2, HB2, HA2, HF2, VS2, VB2, VA2, 1'b0);
            checks++;
            if ({vga_hs2, vga_vs2, vga_de2, sof2, vga_rgb2} !== exp) begin
                fails++;
                $display("FAIL neg_frame pos %0d: got %h expected %h", i,
                         {vga_hs2, vga_vs2, vga_de2, sof2, vga_rgb2}, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (frame_cnt2 !== 16'(FC_EN ? 1 : 0)) begin
            fails++;
            $display("FAIL neg_frame_cnt: got %0d expected %0d", frame_cnt2, FC_EN ? 1 : 0);
        end
        en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_hs();
        test_frame();
        test_en_drop();
        test_reset_mid();
        test_sync_pol();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/disp_timing_ctrl.md
# disp_timing_ctrl

Display timing controller that sequences the colour-bar pattern generator and drives the video output port. It produces the raster counters, hands the pattern generator its active-area pixel coordinates, and registers the returned 24-bit pixel. It re-times sync and data-enable so that hsync, vsync, de and rgb leave the block cycle-aligned. It sits between the pixel-clock domain and the video PHY/encoder.

## Interface
- H_SYNC, 44: hsync pulse width, pixels
- H_BACK, 148: horizontal back porch
- H_ACTIVE, 1920: active pixels per line
- H_FRONT, 88: horizontal front porch
- V_SYNC, 5: vsync width, lines
- V_BACK, 36: vertical back porch
- V_ACTIVE, 1080: active lines
- V_FRONT, 4: vertical front porch
- SYNC_POL, 1: 1 = sync asserted high, 0 = asserted low
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  raster run request
- h_addr  out  12  active-area column to pattern generator, 0 outside active area
- v_addr  out  12  active-area row to pattern generator, 0 outside active area
- data_in  in  24  pixel from pattern generator, valid one cycle after h_addr/v_addr
- vga_hs  out  1  aligned hsync
- vga_vs  out  1  aligned vsync
- vga_de  out  1  aligned data enable
- vga_rgb  out  24  aligned pixel, forced 0 when vga_de=0
- sof  out  1  one-cycle pulse, aligned with the first active pixel of a frame
- frame_cnt  out  16  frames completed (macro-dependent)

## Operation
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters. On wrap, v_cnt increments over 0..V_TOTAL-1 and wraps to 0.
- Line order: sync [0, H_SYNC), back porch, active [H_START, H_START+H_ACTIVE) with H_START = H_SYNC+H_BACK, then front porch. The same order applies vertically with V_START.
- Active area: h_cnt and v_cnt both lie inside their active windows. There, h_addr = h_cnt-H_START and v_addr = v_cnt-V_START; otherwise both are 0.
- Run control, two states:
  - IDLE: counters held at 0, all outputs inactive.
  - RUN: counters advance every cycle.
  - IDLE->RUN on en=1.
  - RUN->IDLE only at frame end (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) with en=0. Deasserting en mid-frame always completes the current frame.
- Sync level is SYNC_POL when inside the sync window and ~SYNC_POL otherwise. In IDLE the syncs sit at ~SYNC_POL.
- vga_rgb = data_in when the delayed de is 1, else 24'h0.
- Counter widths: 12 bits. H_TOTAL and V_TOTAL must each be ≤4096, enforced by an elaboration-time check.

## Timing
- Reset values: h_addr=0, v_addr=0, vga_de=0, vga_rgb=0, sof=0, frame_cnt=0, vga_hs=vga_vs=~SYNC_POL. State is IDLE and counters are 0.
- Cycle t: counters hold value C.
- Cycle t+1: h_addr/v_addr registered from C.
- Cycle t+2: data_in valid for C.
- Cycle t+3: vga_hs, vga_vs, vga_de, vga_rgb and sof for C appear together. Total latency from counters to outputs is 3 cycles; from h_addr to vga_rgb it is 2 cycles.
- First cycle after leaving IDLE: counters are at (0,0), so the first vga_hs assertion occurs 3 cycles after en is sampled high.
- Reset mid-frame: all pipeline stages clear immediately and asynchronously. No partial pixels are emitted after release.
- Frame end: frame_cnt increments on the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1). It wraps at 16'hFFFF -> 0.

## Configuration
- FRAME_CNT_EN defined: frame_cnt counter is implemented as described.
- FRAME_CNT_EN undefined: frame_cnt is tied to 16'h0 and no counter logic is inferred. sof is unaffected.

## Structure
- Shared package disp_pkg holds:
  - the timing-mode constants (1080p60 defaults, plus 720p60 as 1280/110/40/220 horizontal and 720/5/5/20 vertical);
  - the colour constants already used by the pattern generator;
  - the 12-bit coordinate and 24-bit pixel typedefs.
- One sub-module is natural: disp_sync_pipe, a parameterised-depth delay line for the {hs, vs, de, sof} bundle. It is instantiated once with depth 3 (counter stage to output).

## Test plan
- Reset, en=0: all outputs hold reset values for 10,000 cycles and the counters stay at 0.
- en=1 with the 1080p defaults: vga_de high for exactly 1920 consecutive cycles per active line. The line period is 2200 cycles, there are 1080 active lines per 1125-line frame, and vga_hs is high for 44 cycles.
- Alignment: feed data_in = {v_addr[11:0], h_addr[11:0]} delayed by 1 cycle. The first vga_rgb with vga_de=1 equals 24'h000000 coincident with sof, and the last active pixel of the frame equals {12'd1079, 12'd1919}.
- Drop en at line 500: the frame completes through line 1124 and the block then parks in IDLE. frame_cnt increments exactly once and vga_de stays 0 afterwards.
- Reset asserted mid-active-line: vga_de and vga_rgb go to 0 immediately. After release with en=1, output resumes at h_cnt=0, v_cnt=0.
- SYNC_POL=0, 720p parameters, FRAME_CNT_EN undefined: syncs are active-low with widths 40 and 5, the line period is 1650 cycles, and frame_cnt stays 0.
